multi_edge_detector: RTL and testbench

- Parametrised, multi-channel successor to the single-bit rising-edge detector.
- Each channel has:
  - an optional input synchroniser;
  - a per-channel edge mode (off, rise, fall or both);
  - a retriggerable stretched output pulse;
  - a sticky event flag;
  - a saturating edge counter, read out through a channel-select mux.
- Sits between raw GPIO/status inputs and interrupt/event logic.

---
 rtl/multi_edge_detector.sv | 128 ++++++++++++
 tb/tb_multi_edge_detector.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/multi_edge_detector.sv
// Multi-channel edge detector: optional input synchroniser, per-channel edge mode,
// retriggerable stretched pulse, sticky flag and saturating edge counter per channel.
module multi_edge_detector #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned PULSE_LEN   = 1,
  parameter int unsigned CNT_W       = 8,
  localparam int unsigned SelW       = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   din,
  input  logic [2*WIDTH-1:0] mode,
  input  logic [WIDTH-1:0]   clr,
  input  logic [SelW-1:0]    cnt_sel,
  output logic [WIDTH-1:0]   dout,
  output logic [WIDTH-1:0]   sticky,
  output logic [CNT_W-1:0]   cnt_out
);

  localparam int unsigned TimerW = $clog2(PULSE_LEN + 1);
  localparam logic [TimerW-1:0] PulseLoad = TimerW'(PULSE_LEN);
  localparam logic [CNT_W-1:0]  CntMax    = '1;

  logic [WIDTH-1:0] s;

  if (SYNC_STAGES == 0) begin : g_no_sync
    assign s = din;
  end else begin : g_sync
    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_d [SYNC_STAGES];

    always_comb begin
      sync_d[0] = din;
      for (int k = 1; k < int'(SYNC_STAGES); k++) begin
        sync_d[k] = sync_q[k-1];
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        sync_q <= '{default: '0};
      end else begin
        sync_q <= sync_d;
      end
    end

    assign s = sync_q[SYNC_STAGES-1];
  end

  logic [WIDTH-1:0]  prev_q, prev_d;
  logic [WIDTH-1:0]  sticky_q, sticky_d;
  logic [WIDTH-1:0]  rise, fall, edge_hit;
  logic [TimerW-1:0] timer_q [WIDTH];
  logic [TimerW-1:0] timer_d [WIDTH];
  logic [CNT_W-1:0]  cnt_q [WIDTH];
  logic [CNT_W-1:0]  cnt_d [WIDTH];

  // prev follows s in every mode so enabling a channel never sees stale history.
  assign prev_d = s;
  assign rise   = s & ~prev_q;
  assign fall   = ~s & prev_q;

  always_comb begin
    edge_hit = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      case (mode[2*i +: 2])
        2'b01:   edge_hit[i] = rise[i];
        2'b10:   edge_hit[i] = fall[i];
        2'b11:   edge_hit[i] = rise[i] | fall[i];
        default: edge_hit[i] = 1'b0;
      endcase
    end
  end

  always_comb begin
    sticky_d = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      timer_d[i] = '0;
      cnt_d[i]   = cnt_q[i];
      if (edge_hit[i]) begin
        timer_d[i] = PulseLoad;
      end else if (timer_q[i] != '0) begin
        timer_d[i] = timer_q[i] - 1'b1;
      end
      sticky_d[i] = edge_hit[i] | (sticky_q[i] & ~clr[i]);
      // An edge coinciding with clr counts as the first edge after the clear.
      if (clr[i]) begin
        cnt_d[i] = edge_hit[i] ? CNT_W'(1) : '0;
      end else if (edge_hit[i] && (cnt_q[i] != CntMax)) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q   <= '0;
      sticky_q <= '0;
      timer_q  <= '{default: '0};
      cnt_q    <= '{default: '0};
    end else begin
      prev_q   <= prev_d;
      sticky_q <= sticky_d;
      timer_q  <= timer_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    dout = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      dout[i] = (timer_q[i] != '0);
    end
  end

  assign sticky = sticky_q;

  always_comb begin
    cnt_out = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (cnt_sel == SelW'(i)) begin
        cnt_out = cnt_q[i];
      end
    end
  end

endmodule

// File: tb/tb_multi_edge_detector.sv
// Bench for multi_edge_detector: two configurations share one stimulus stream; a reference
// model pushes expected outputs into a queue and a negedge monitor pops and compares.
module tb_multi_edge_detector;

  localparam int W = 6;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] din;
  logic [2*W-1:0] mode;
  logic [W-1:0] clr;
  logic [2:0]   cnt_sel;
  logic [W-1:0] dout_a, sticky_a, dout_b, sticky_b;
  logic [7:0]   cnt_a;
  logic [2:0]   cnt_b;

  always #5 clk = ~clk;

  multi_edge_detector #(
    .WIDTH(W), .SYNC_STAGES(0), .PULSE_LEN(1), .CNT_W(8)
  ) u_dut_a (
    .clk(clk), .reset(reset), .din(din), .mode(mode), .clr(clr), .cnt_sel(cnt_sel),
    .dout(dout_a), .sticky(sticky_a), .cnt_out(cnt_a)
  );

  multi_edge_detector #(
    .WIDTH(W), .SYNC_STAGES(2), .PULSE_LEN(4), .CNT_W(3)
  ) u_dut_b (
    .clk(clk), .reset(reset), .din(din), .mode(mode), .clr(clr), .cnt_sel(cnt_sel),
    .dout(dout_b), .sticky(sticky_b), .cnt_out(cnt_b)
  );

  typedef struct packed {
    logic [W-1:0] dout_a;
    logic [W-1:0] stk_a;
    logic [W-1:0] dout_b;
    logic [W-1:0] stk_b;
    logic [7:0]   cnt_a;
    logic [2:0]   cnt_b;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  bit   running = 1'b1;

  // Reference model: per-instance parameters and abstract channel state.
  int         sync_n[2] = '{0, 2};
  int         plen[2]   = '{1, 4};
  int         cmax[2]   = '{255, 7};
  bit [W-1:0] din_hist[$];
  bit [W-1:0] prev_m[2];
  bit [W-1:0] stk_m[2];
  int         cnt_m[2][W];
  int         last_e[2][W];
  int         kcyc = 0;

  function automatic void model_reset();
    din_hist.delete();
    for (int n = 0; n < 2; n++) begin
      prev_m[n] = '0;
      stk_m[n]  = '0;
      for (int c = 0; c < W; c++) begin
        cnt_m[n][c]  = 0;
        last_e[n][c] = -1000000;
      end
    end
  endfunction

  function automatic void model_step(bit [W-1:0] d, bit [2*W-1:0] m, bit [W-1:0] c);
    bit [W-1:0] s;
    bit r, f, e;
    kcyc++;
    din_hist.push_back(d);
    if (din_hist.size() > 3) void'(din_hist.pop_front());
    for (int n = 0; n < 2; n++) begin
      // s is the input value seen SYNC posedges ago; zero until that many samples since reset.
      s = '0;
      if (din_hist.size() > sync_n[n]) s = din_hist[din_hist.size() - 1 - sync_n[n]];
      for (int ch = 0; ch < W; ch++) begin
        r = s[ch] && !prev_m[n][ch];
        f = !s[ch] && prev_m[n][ch];
        case (m[2*ch +: 2])
          2'b01:   e = r;
          2'b10:   e = f;
          2'b11:   e = r || f;
          default: e = 1'b0;
        endcase
        if (e) last_e[n][ch] = kcyc;
        if (c[ch]) begin
          stk_m[n][ch] = e;
          cnt_m[n][ch] = e ? 1 : 0;
        end else if (e) begin
          stk_m[n][ch] = 1'b1;
          if (cnt_m[n][ch] < cmax[n]) cnt_m[n][ch]++;
        end
      end
      prev_m[n] = s;
    end
  endfunction

  function automatic bit [W-1:0] dout_of(int n);
    bit [W-1:0] v = '0;
    for (int ch = 0; ch < W; ch++) v[ch] = (kcyc - last_e[n][ch]) < plen[n];
    return v;
  endfunction

  function automatic exp_t exp_now(bit [2:0] sel);
    exp_t e;
    e.dout_a = dout_of(0);
    e.dout_b = dout_of(1);
    e.stk_a  = stk_m[0];
    e.stk_b  = stk_m[1];
    e.cnt_a  = (int'(sel) < W) ? 8'(cnt_m[0][sel]) : 8'd0;
    e.cnt_b  = (int'(sel) < W) ? 3'(cnt_m[1][sel]) : 3'd0;
    return e;
  endfunction

  function automatic void chk(string name, logic [7:0] act, logic [7:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s got=%h want=%h at %0t", name, act, req, $time);
    end
  endfunction

  // Inputs change 1 time unit after posedge; reset acts asynchronously at that moment.
  task automatic drive(bit r, bit [W-1:0] d, bit [2*W-1:0] m, bit [W-1:0] c, bit [2:0] sel);
    @(posedge clk);
    #1;
    reset   = r;
    din     = d;
    mode    = m;
    clr     = c;
    cnt_sel = sel;
    if (r) model_reset();
    exp_q.push_back(exp_now(sel));
    if (!r) model_step(d, m, c);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (running) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL scoreboard_empty got=0 want=1 at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          chk("dout_a", 8'(dout_a), 8'(e.dout_a));
          chk("sticky_a", 8'(sticky_a), 8'(e.stk_a));
          chk("cnt_a", cnt_a, e.cnt_a);
          chk("dout_b", 8'(dout_b), 8'(e.dout_b));
          chk("sticky_b", 8'(sticky_b), 8'(e.stk_b));
          chk("cnt_b", 8'(cnt_b), 8'(e.cnt_b));
        end
      end
    end
  end

  localparam bit [2*W-1:0] AllRise = {W{2'b01}};

  initial begin : stimulus
    bit [W-1:0]   d;
    bit [2*W-1:0] m;
    bit [W-1:0]   c;
    bit           r;
    reset   = 1'b1;
    din     = 6'h10;
    mode    = AllRise;
    clr     = '0;
    cnt_sel = 3'd4;
    model_reset();

    // din[4] held high through reset: one rise at the first post-reset sample.
    repeat (3) drive(1'b1, 6'h10, AllRise, '0, 3'd4);
    repeat (8) drive(1'b0, 6'h10, AllRise, '0, 3'd4);

    // Channel 5 toggles while off, then rise mode enabled with input steady high.
    for (int i = 0; i < 10; i++) drive(1'b0, (i % 2 == 1) ? 6'h20 : 6'h00, '0, '0, 3'd5);
    repeat (8) drive(1'b0, 6'h20, AllRise, '0, 3'd5);

    // Channel 1 both-edges, channel 2 falls only, 2-cycle spacing.
    for (int i = 0; i < 10; i++)
      drive(1'b0, (i % 4 >= 2) ? 6'h06 : 6'h00, 12'b01_01_01_10_11_01, '0, 3'(1 + i % 2));

    // Channel 3 saturation, then clr alone, then clr together with rising input.
    for (int i = 0; i < 24; i++) drive(1'b0, (i % 2 == 1) ? 6'h08 : 6'h00, AllRise, '0, 3'd3);
    repeat (4) drive(1'b0, 6'h00, AllRise, 6'h08, 3'd3);
    drive(1'b0, 6'h08, AllRise, 6'h08, 3'd3);
    repeat (4) drive(1'b0, 6'h08, AllRise, '0, 3'd3);

    // Retrigger: rises on channel 0 two cycles apart, then reset mid-pulse.
    drive(1'b0, 6'h01, AllRise, '0, 3'd0);
    drive(1'b0, 6'h00, AllRise, '0, 3'd0);
    drive(1'b0, 6'h01, AllRise, '0, 3'd0);
    repeat (3) drive(1'b0, 6'h01, AllRise, '0, 3'd0);
    drive(1'b1, 6'h01, AllRise, '0, 3'd0);
    repeat (8) drive(1'b0, 6'h00, AllRise, '0, 3'd0);

    // Saturate the 8-bit counter of channel 2 on the first instance.
    for (int i = 0; i < 270; i++)
      drive(1'b0, (i % 2 == 1) ? 6'h04 : 6'h00, {W{2'b11}}, '0, 3'd2);

    // Randomised traffic with occasional mode changes, clears and resets.
    d = '0;
    m = AllRise;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 15) == 0) m = 12'($urandom);
      if ($urandom_range(0, 3) != 0) d = d ^ 6'($urandom & $urandom);
      c = ($urandom_range(0, 15) == 0) ? 6'($urandom) : 6'h00;
      r = ($urandom_range(0, 199) == 0);
      drive(r, d, m, c, 3'($urandom));
    end

    @(negedge clk);
    #1;
    running = 1'b0;
    chk("scoreboard_drained", 8'(exp_q.size()), 8'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
